// File: rtl/trigger_pkg.sv
// Shared types and helpers for the multi-stage trigger sequencer.
// Optional build macro TRIG_EDGE_EN adds per-stage edge qualification.
package trigger_pkg;

  localparam int unsigned DATA_W_DEF = 33;
  localparam int unsigned OFFS_W_DEF = 17;
  localparam int unsigned STAGES_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ARMED     = 2'd1,
    ST_TRIGGERED = 2'd2
  } state_e;

  // Width of the stage index; a single-stage unit still carries one bit.
  function automatic int unsigned sel_width(input int unsigned stages);
    return (stages > 1) ? $clog2(stages) : 1;
  endfunction

  // Limit a requested final-stage index to the stages that exist.
  function automatic int unsigned clamp_last(input int unsigned last, input int unsigned stages);
    return (last > stages - 1) ? stages - 1 : last;
  endfunction

endpackage

// File: rtl/trigger_sequencer_if.sv
// Configuration, data and status bundle of the trigger sequencer.
// Optional build macro TRIG_EDGE_EN adds the cfg_edge field.
interface trigger_sequencer_if #(
  parameter int unsigned DATA_W = trigger_pkg::DATA_W_DEF,
  parameter int unsigned OFFS_W = trigger_pkg::OFFS_W_DEF,
  parameter int unsigned STAGES = trigger_pkg::STAGES_DEF
) ();
  import trigger_pkg::*;

  localparam int unsigned SW = sel_width(STAGES);

  logic                     start;
  logic [DATA_W-1:0]        data;
  logic [STAGES*DATA_W-1:0] cfg_value;
  logic [STAGES*DATA_W-1:0] cfg_mask;
  logic [STAGES*OFFS_W-1:0] cfg_offset;
  logic [SW-1:0]            cfg_last;
`ifdef TRIG_EDGE_EN
  logic [STAGES-1:0]        cfg_edge;
`endif
  logic                     trig;
  logic                     triggered;
  logic [SW-1:0]            stage;
  logic                     busy;

  // Capture controller side.
  modport master (
`ifdef TRIG_EDGE_EN
    output cfg_edge,
`endif
    output start, data, cfg_value, cfg_mask, cfg_offset, cfg_last,
    input  trig, triggered, stage, busy
  );

  // Trigger unit side.
  modport slave (
`ifdef TRIG_EDGE_EN
    input  cfg_edge,
`endif
    input  start, data, cfg_value, cfg_mask, cfg_offset, cfg_last,
    output trig, triggered, stage, busy
  );

endinterface

// File: rtl/trigger_stage_cmp.sv
// Masked pattern compare for the currently selected stage.
// Under TRIG_EDGE_EN an edge-enabled stage also requires that the previous
// sample did not already match, so only a transition into the pattern counts.
module trigger_stage_cmp #(
  parameter int unsigned DATA_W = 33
) (
  input  logic [DATA_W-1:0] data,
  input  logic [DATA_W-1:0] value,
  input  logic [DATA_W-1:0] mask,
`ifdef TRIG_EDGE_EN
  input  logic [DATA_W-1:0] prev_data,
  input  logic              edge_en,
`endif
  output logic              hit
);

  logic level_hit;

  // A cleared mask bit is a don't-care, so an all-zero mask always matches.
  assign level_hit = ((data & mask) == (value & mask));

`ifdef TRIG_EDGE_EN
  logic prev_hit;
  assign prev_hit = ((prev_data & mask) == (value & mask));
  assign hit      = level_hit & (~edge_en | ~prev_hit);
`else
  assign hit      = level_hit;
`endif

endmodule

// File: rtl/trigger_sequencer.sv
// Multi-stage trigger: walks up to STAGES masked compares, each at a
// programmable cycle offset after the previous one, then emits a one-cycle
// trig pulse and a sticky triggered level until start drops.
// Optional build macro TRIG_EDGE_EN enables per-stage edge qualification.
module trigger_sequencer
  import trigger_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned OFFS_W = OFFS_W_DEF,
  parameter int unsigned STAGES = STAGES_DEF
) (
  input logic              clock,
  input logic              reset,
  trigger_sequencer_if.slave bus
);

  localparam int unsigned SW = sel_width(STAGES);

  state_e            state_q, state_d;
  logic [OFFS_W-1:0] count_q, count_d;
  logic [SW-1:0]     stage_q, stage_d;
  logic              trig_q, trig_d;
  logic              latch_cfg;

  // Configuration snapshot taken when leaving IDLE.
  logic [DATA_W-1:0] value_q  [STAGES];
  logic [DATA_W-1:0] mask_q   [STAGES];
  logic [OFFS_W-1:0] offset_q [STAGES];
  logic [SW-1:0]     last_q;

  logic [31:0]       last_ext;
  logic [SW-1:0]     last_clamped;

  logic [DATA_W-1:0] cur_value;
  logic [DATA_W-1:0] cur_mask;
  logic [OFFS_W-1:0] cur_offset;
  logic              at_offset;
  logic              hit;

  assign last_ext     = 32'(bus.cfg_last);
  assign last_clamped = SW'(clamp_last(last_ext, STAGES));

  assign cur_value  = value_q[stage_q];
  assign cur_mask   = mask_q[stage_q];
  assign cur_offset = offset_q[stage_q];
  assign at_offset  = (count_q == cur_offset);

`ifdef TRIG_EDGE_EN
  logic [STAGES-1:0] edge_q;
  logic [DATA_W-1:0] prev_data_q;

  // Previous bus sample for transition detection.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      prev_data_q <= '0;
    end else begin
      prev_data_q <= bus.data;
    end
  end

  // Edge-enable bits are snapshotted together with the rest of the config.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      edge_q <= '0;
    end else if (latch_cfg) begin
      edge_q <= bus.cfg_edge;
    end
  end

  trigger_stage_cmp #(
    .DATA_W (DATA_W)
  ) u_cmp (
    .data      (bus.data),
    .value     (cur_value),
    .mask      (cur_mask),
    .prev_data (prev_data_q),
    .edge_en   (edge_q[stage_q]),
    .hit       (hit)
  );
`else
  trigger_stage_cmp #(
    .DATA_W (DATA_W)
  ) u_cmp (
    .data  (bus.data),
    .value (cur_value),
    .mask  (cur_mask),
    .hit   (hit)
  );
`endif

  // State register with the stage counter and registered trig pulse.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      stage_q <= '0;
      trig_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      stage_q <= stage_d;
      trig_q  <= trig_d;
    end
  end

  // Config snapshot; later changes on the bus are ignored until back in IDLE.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      last_q <= '0;
      for (int k = 0; k < STAGES; k++) begin
        value_q[k]  <= '0;
        mask_q[k]   <= '0;
        offset_q[k] <= '0;
      end
    end else if (latch_cfg) begin
      last_q <= last_clamped;
      for (int k = 0; k < STAGES; k++) begin
        value_q[k]  <= bus.cfg_value[k*DATA_W +: DATA_W];
        mask_q[k]   <= bus.cfg_mask[k*DATA_W +: DATA_W];
        offset_q[k] <= bus.cfg_offset[k*OFFS_W +: OFFS_W];
      end
    end
  end

  // Next-state logic: wait out each offset, compare, advance or restart.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    stage_d   = stage_q;
    trig_d    = 1'b0;
    latch_cfg = 1'b0;
    case (state_q)
      ST_IDLE: begin
        count_d = '0;
        stage_d = '0;
        if (bus.start) begin
          latch_cfg = 1'b1;
          state_d   = ST_ARMED;
        end
      end
      ST_ARMED: begin
        if (!bus.start) begin
          state_d = ST_IDLE;
          count_d = '0;
          stage_d = '0;
        end else if (!at_offset) begin
          count_d = count_q + OFFS_W'(1);
        end else if (hit) begin
          if (stage_q == last_q) begin
            // Stage and count stay frozen while triggered.
            state_d = ST_TRIGGERED;
            trig_d  = 1'b1;
          end else begin
            stage_d = stage_q + SW'(1);
            count_d = '0;
          end
        end else begin
          // Any mismatch restarts the whole sequence.
          stage_d = '0;
          count_d = '0;
        end
      end
      ST_TRIGGERED: begin
        if (!bus.start) begin
          state_d = ST_IDLE;
          count_d = '0;
          stage_d = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        count_d = '0;
        stage_d = '0;
      end
    endcase
  end

  // Status outputs decoded from registered state.
  always_comb begin
    bus.trig      = trig_q;
    bus.triggered = (state_q == ST_TRIGGERED);
    bus.busy      = (state_q == ST_ARMED);
    bus.stage     = stage_q;
  end

endmodule

// File: tb/tb_trigger_sequencer.sv
// Scoreboard bench for trigger_sequencer (three stages so cfg_last clamping
// is observable). Build with TRIG_EDGE_EN to include the edge scenario.
module tb_trigger_sequencer;
  import trigger_pkg::*;

  localparam int unsigned DATA_W = 33;
  localparam int unsigned OFFS_W = 17;
  localparam int unsigned STAGES = 3;

  localparam logic [DATA_W-1:0] ONES = {DATA_W{1'b1}};

  // Expected {trig, triggered, busy, stage[1:0]}.
  localparam logic [4:0] O_IDLE = 5'b00000;
  localparam logic [4:0] O_A0   = 5'b00100;
  localparam logic [4:0] O_A1   = 5'b00101;
  localparam logic [4:0] O_A2   = 5'b00110;
  localparam logic [4:0] O_P0   = 5'b11000;
  localparam logic [4:0] O_P1   = 5'b11001;
  localparam logic [4:0] O_P2   = 5'b11010;
  localparam logic [4:0] O_H0   = 5'b01000;
  localparam logic [4:0] O_H1   = 5'b01001;

  typedef struct {
    string      tag;
    logic [4:0] outs;
  } exp_t;

  logic clock = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;
  exp_t exp_q[$];
  exp_t mon_e;
  logic [4:0] obs;

  always #5 clock = ~clock;

  trigger_sequencer_if #(
    .DATA_W (DATA_W),
    .OFFS_W (OFFS_W),
    .STAGES (STAGES)
  ) bus ();

  trigger_sequencer #(
    .DATA_W (DATA_W),
    .OFFS_W (OFFS_W),
    .STAGES (STAGES)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  assign obs = {bus.trig, bus.triggered, bus.busy, bus.stage};

  task automatic check_val(input string tag, input logic [4:0] got, input logic [4:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%b want=%b (trig,triggered,busy,stage)", tag, got, want);
    end
  endtask

  // Pop one expectation per clock, sampled just after the edge.
  always @(posedge clock) begin
    #1;
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      check_val(mon_e.tag, obs, mon_e.outs);
    end
  end

  // Called at a falling edge: drive one cycle of stimulus, queue the outputs
  // expected after the next rising edge, return at the following falling edge.
  task automatic step(input logic st, input logic [DATA_W-1:0] d, input string tag,
                      input logic [4:0] want);
    exp_t e;
    bus.start = st;
    bus.data  = d;
    e.tag     = tag;
    e.outs    = want;
    exp_q.push_back(e);
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic set_stage(input int k, input logic [DATA_W-1:0] v, input logic [DATA_W-1:0] m,
                           input logic [OFFS_W-1:0] off);
    bus.cfg_value[k*DATA_W +: DATA_W]  = v;
    bus.cfg_mask[k*DATA_W +: DATA_W]   = m;
    bus.cfg_offset[k*OFFS_W +: OFFS_W] = off;
  endtask

  initial begin
    reset          = 1'b1;
    bus.start      = 1'b0;
    bus.data       = '0;
    bus.cfg_value  = '0;
    bus.cfg_mask   = '0;
    bus.cfg_offset = '0;
    bus.cfg_last   = '0;
`ifdef TRIG_EDGE_EN
    bus.cfg_edge   = '0;
`endif
    @(negedge clock);
    check_val("reset", obs, O_IDLE);
    @(negedge clock);
    reset = 1'b0;

    // Single stage, offset 1: compare happens on the second armed cycle.
    set_stage(0, 33'd4, ONES, 17'd1);
    bus.cfg_last = 2'd0;
    step(1'b0, 33'd0, "t1_idle", O_IDLE);
    step(1'b1, 33'd0, "t1_arm", O_A0);
    step(1'b1, 33'd4, "t1_early", O_A0);
    step(1'b1, 33'd0, "t1_miss", O_A0);
    step(1'b1, 33'd0, "t1_c0", O_A0);
    step(1'b1, 33'd4, "t1_hit", O_P0);
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 33'd4, $sformatf("t1_hold%0d", i), O_H0);
    end
    step(1'b0, 33'd0, "t1_drop", O_IDLE);

    // Two stages: AA at offset 0, then 55 three waits later.
    set_stage(0, 33'h0AA, ONES, 17'd0);
    set_stage(1, 33'h055, ONES, 17'd3);
    bus.cfg_last = 2'd1;
    step(1'b1, 33'd0, "t2_arm", O_A0);
    step(1'b1, 33'h0AA, "t2_s0", O_A1);
    step(1'b1, 33'h000, "t2_w0", O_A1);
    step(1'b1, 33'h000, "t2_w1", O_A1);
    step(1'b1, 33'h000, "t2_w2", O_A1);
    step(1'b1, 33'h055, "t2_s1", O_P1);
    step(1'b1, 33'h000, "t2_held", O_H1);
    step(1'b0, 33'h000, "t2_drop", O_IDLE);

    // Same, but the second slot misses and the sequence restarts.
    step(1'b1, 33'd0, "t2b_arm", O_A0);
    step(1'b1, 33'h0AA, "t2b_s0", O_A1);
    step(1'b1, 33'h000, "t2b_w0", O_A1);
    step(1'b1, 33'h000, "t2b_w1", O_A1);
    step(1'b1, 33'h000, "t2b_w2", O_A1);
    step(1'b1, 33'h000, "t2b_miss", O_A0);
    step(1'b1, 33'h0AA, "t2b_s0b", O_A1);
    step(1'b1, 33'h000, "t2b_w3", O_A1);
    step(1'b1, 33'h000, "t2b_w4", O_A1);
    step(1'b1, 33'h000, "t2b_w5", O_A1);
    step(1'b1, 33'h055, "t2b_s1", O_P1);
    step(1'b0, 33'h000, "t2b_drop", O_IDLE);

    // Three stages, cfg_last=3 clamps to 2; config is scrambled once armed.
    set_stage(0, 33'h1, ONES, 17'd0);
    set_stage(1, 33'h2, 33'h0F, 17'd0);
    set_stage(2, 33'h1_0000_0000, ONES, 17'd2);
    bus.cfg_last = 2'd3;
    step(1'b1, 33'd0, "t3_arm", O_A0);
    bus.cfg_value  = '1;
    bus.cfg_offset = '0;
    bus.cfg_last   = 2'd0;
    step(1'b1, 33'h1, "t3_s0", O_A1);
    step(1'b1, 33'hF2, "t3_s1_masked", O_A2);
    step(1'b1, 33'h0, "t3_w0", O_A2);
    step(1'b1, 33'h0, "t3_w1", O_A2);
    step(1'b1, 33'h1_0000_0000, "t3_s2", O_P2);
    step(1'b0, 33'h0, "t3_drop", O_IDLE);

    // Reset while in stage 2, then re-arm with freshly latched config.
    set_stage(0, 33'h1, ONES, 17'd0);
    set_stage(1, 33'h0, 33'h0, 17'd0);
    set_stage(2, 33'h7, ONES, 17'd5);
    bus.cfg_last = 2'd2;
    step(1'b1, 33'h0, "t4_arm", O_A0);
    step(1'b1, 33'h1, "t4_s0", O_A1);
    step(1'b1, 33'h123, "t4_s1_mask0", O_A2);
    step(1'b1, 33'h0, "t4_wait", O_A2);
    reset = 1'b1;
    #1;
    check_val("t4_rst_async", obs, O_IDLE);
    set_stage(0, 33'h9, ONES, 17'd0);
    @(posedge clock);
    @(negedge clock);
    check_val("t4_rst_hold", obs, O_IDLE);
    reset = 1'b0;
    step(1'b1, 33'h9, "t4_rearm", O_A0);
    step(1'b1, 33'h9, "t4_s0_fresh", O_A1);
    step(1'b0, 33'h0, "t4_drop", O_IDLE);

`ifdef TRIG_EDGE_EN
    // Edge stage: a level already present at arm must not fire.
    set_stage(0, 33'h5, ONES, 17'd0);
    bus.cfg_last = 2'd0;
    bus.cfg_edge = 3'b001;
    step(1'b0, 33'h5, "e_idle", O_IDLE);
    step(1'b1, 33'h5, "e_arm", O_A0);
    step(1'b1, 33'h5, "e_level0", O_A0);
    step(1'b1, 33'h5, "e_level1", O_A0);
    step(1'b1, 33'h0, "e_low", O_A0);
    step(1'b1, 33'h5, "e_rise", O_P0);
    step(1'b0, 33'h0, "e_drop", O_IDLE);
`endif

    @(posedge clock);
    @(negedge clock);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
